// File: rtl/hps_cmd_pkg.sv
// Shared definitions for the HPS command decoder: command codes, FSM state
// encoding and the width of the per-transaction word counter.
package hps_cmd_pkg;

    localparam int WCNT_W = 8;

    localparam logic [7:0] CMD_SET_JOY     = 8'h01;
    localparam logic [7:0] CMD_SET_BUTTONS = 8'h02;
    localparam logic [7:0] CMD_CFG_WRITE   = 8'h03;
    localparam logic [7:0] CMD_CFG_READ    = 8'h04;
    localparam logic [7:0] CMD_GET_STATUS  = 8'h05;
    localparam logic [7:0] CMD_ECHO        = 8'h06;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage

// File: rtl/hps_cmd_decoder_if.sv
// Word-level link between the SPI slave (master side: delivers received
// words and framing) and the command decoder (slave side: returns replies).
interface hps_cmd_decoder_if;

    logic        io_enable;
    logic        io_strobe;
    logic [15:0] io_din;
    logic [15:0] io_dout;

    modport master (
        output io_enable,
        output io_strobe,
        output io_din,
        input  io_dout
    );

    modport slave (
        input  io_enable,
        input  io_strobe,
        input  io_din,
        output io_dout
    );

endinterface

// File: rtl/hps_cfg_regfile.sv
// Config register file: CFG_WORDS x 16-bit registers, one synchronous write
// port, one combinational read port. Out-of-range addresses read as zero and
// are never written, so the command decoder can present raw word counts.
module hps_cfg_regfile
    import hps_cmd_pkg::*;
#(
    parameter int CFG_WORDS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    we_i,
    input  logic [WCNT_W-1:0]       waddr_i,
    input  logic [15:0]             wdata_i,
    input  logic [WCNT_W-1:0]       raddr_i,
    output logic [15:0]             rdata_o,
    output logic [CFG_WORDS*16-1:0] cfg_o
);

    logic [15:0] mem_q [CFG_WORDS];
    logic [15:0] rdata_s;

    // Register storage with synchronous active-low clear and addressed write.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < CFG_WORDS; i++) begin
            if (!rst_n_i) begin
                mem_q[i] <= 16'h0000;
            end else if (we_i && (waddr_i == WCNT_W'(i))) begin
                mem_q[i] <= wdata_i;
            end else begin
                mem_q[i] <= mem_q[i];
            end
        end
    end

    // Address-decoded read; no match (out of range) yields zero.
    always_comb begin
        rdata_s = 16'h0000;
        for (int i = 0; i < CFG_WORDS; i++) begin
            rdata_s = rdata_s | ((raddr_i == WCNT_W'(i)) ? mem_q[i] : 16'h0000);
        end
    end

    assign rdata_o = rdata_s;

    genvar k;
    generate
        for (k = 0; k < CFG_WORDS; k++) begin : g_flat
            assign cfg_o[16*k +: 16] = mem_q[k];
        end
    endgenerate

endmodule

// File: rtl/hps_cmd_decoder.sv
// HPS command decoder: frames io_enable windows into command + data words,
// executes joystick/button/config/status commands and prepares the reply
// word the SPI slave shifts out on the next word.
// Optional build macro: HPS_CMD_ECHO_EN enables command 0x06 (ECHO loopback).
module hps_cmd_decoder
    import hps_cmd_pkg::*;
#(
    parameter int          CFG_WORDS = 8,
    parameter logic [15:0] CORE_ID   = 16'h0001
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    hps_cmd_decoder_if.slave        io,
    input  logic [15:0]             status_in,
    output logic [31:0]             joystick_0,
    output logic [15:0]             buttons,
    output logic [CFG_WORDS*16-1:0] cfg_out,
    output logic                    cfg_changed,
    output logic                    cmd_active,
    output logic [7:0]              cmd_code
);

    localparam logic [WCNT_W:0] CFG_WORDS_L = (WCNT_W+1)'(CFG_WORDS);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]        cmd_code_q, cmd_code_d;
    logic [15:0]       io_dout_q, io_dout_d;
    logic [31:0]       joystick_q, joystick_d;
    logic [15:0]       buttons_q, buttons_d;
    logic [15:0]       status_cap_q, status_cap_d;
    logic              cfg_written_q, cfg_written_d;
    logic              cfg_changed_q, cfg_changed_d;
    logic              cmd_active_q, cmd_active_d;

    logic              cfg_we_s;
    logic [WCNT_W-1:0] cfg_raddr_s;
    logic [15:0]       cfg_rdata_s;
    logic [WCNT_W:0]   next_idx_s;
    logic [WCNT_W-1:0] next_raddr_s;
    logic              strobe_s;

    // Strobes outside a frame are meaningless and must not move the FSM.
    assign strobe_s   = io.io_enable & io.io_strobe;
    // Index of the word whose reply is prepared at this strobe; clamped so a
    // saturated counter still points out of range (reads as zero).
    assign next_idx_s   = {1'b0, word_cnt_q} + {{WCNT_W{1'b0}}, 1'b1};
    assign next_raddr_s = next_idx_s[WCNT_W] ? {WCNT_W{1'b1}} : next_idx_s[WCNT_W-1:0];

    hps_cfg_regfile #(
        .CFG_WORDS (CFG_WORDS)
    ) u_cfg (
        .clk_i   (clk_sys),
        .rst_n_i (reset_n),
        .we_i    (cfg_we_s),
        .waddr_i (word_cnt_q),
        .wdata_i (io.io_din),
        .raddr_i (cfg_raddr_s),
        .rdata_o (cfg_rdata_s),
        .cfg_o   (cfg_out)
    );

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            cmd_code_q    <= 8'h00;
            io_dout_q     <= CORE_ID;
            joystick_q    <= 32'h0000_0000;
            buttons_q     <= 16'h0000;
            status_cap_q  <= 16'h0000;
            cfg_written_q <= 1'b0;
            cfg_changed_q <= 1'b0;
            cmd_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            cmd_code_q    <= cmd_code_d;
            io_dout_q     <= io_dout_d;
            joystick_q    <= joystick_d;
            buttons_q     <= buttons_d;
            status_cap_q  <= status_cap_d;
            cfg_written_q <= cfg_written_d;
            cfg_changed_q <= cfg_changed_d;
            cmd_active_q  <= cmd_active_d;
        end
    end

    // Next-state, command execution and reply selection.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        cmd_code_d    = cmd_code_q;
        io_dout_d     = io_dout_q;
        joystick_d    = joystick_q;
        buttons_d     = buttons_q;
        status_cap_d  = status_cap_q;
        cfg_written_d = cfg_written_q;
        cfg_changed_d = 1'b0;
        cmd_active_d  = cmd_active_q;
        cfg_we_s      = 1'b0;
        cfg_raddr_s   = '0;

        case (state_q)
            IDLE: begin
                io_dout_d    = CORE_ID;
                cmd_active_d = 1'b0;
                if (strobe_s) begin
                    cmd_code_d   = io.io_din[7:0];
                    word_cnt_d   = '0;
                    state_d      = DATA;
                    cmd_active_d = 1'b1;
                    status_cap_d = status_in;
                    // Reply for data word 0 goes out while word 0 is shifted.
                    case (io.io_din[7:0])
                        CMD_CFG_READ:   io_dout_d = cfg_rdata_s;
                        CMD_GET_STATUS: io_dout_d = status_in;
                        default:        io_dout_d = 16'h0000;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                if (!io.io_enable) begin
                    // Frame ended (or aborted): partial writes are kept.
                    state_d       = IDLE;
                    cmd_active_d  = 1'b0;
                    io_dout_d     = CORE_ID;
                    cfg_changed_d = cfg_written_q;
                    cfg_written_d = 1'b0;
                end else if (io.io_strobe) begin
                    word_cnt_d  = (word_cnt_q == {WCNT_W{1'b1}}) ? word_cnt_q
                                                                 : next_idx_s[WCNT_W-1:0];
                    cfg_raddr_s = next_raddr_s;
                    case (cmd_code_q)
                        CMD_SET_JOY: begin
                            io_dout_d = 16'h0000;
                            if (word_cnt_q == WCNT_W'(0)) begin
                                joystick_d[15:0] = io.io_din;
                            end else if (word_cnt_q == WCNT_W'(1)) begin
                                joystick_d[31:16] = io.io_din;
                            end else begin
                                joystick_d = joystick_q;
                            end
                        end
                        CMD_SET_BUTTONS: begin
                            io_dout_d = 16'h0000;
                            if (word_cnt_q == WCNT_W'(0)) begin
                                buttons_d = io.io_din;
                            end else begin
                                buttons_d = buttons_q;
                            end
                        end
                        CMD_CFG_WRITE: begin
                            io_dout_d = 16'h0000;
                            if ({1'b0, word_cnt_q} < CFG_WORDS_L) begin
                                cfg_we_s      = 1'b1;
                                cfg_written_d = 1'b1;
                            end else begin
                                cfg_we_s = 1'b0;
                            end
                        end
                        CMD_CFG_READ:   io_dout_d = cfg_rdata_s;
                        CMD_GET_STATUS: io_dout_d = status_cap_q;
`ifdef HPS_CMD_ECHO_EN
                        CMD_ECHO:       io_dout_d = io.io_din;
`endif
                        default:        io_dout_d = 16'h0000;
                    endcase
                end else begin
                    state_d = DATA;
                end
            end

            default: begin
                state_d      = IDLE;
                cmd_active_d = 1'b0;
                io_dout_d    = CORE_ID;
            end
        endcase
    end

    assign io.io_dout  = io_dout_q;
    assign joystick_0  = joystick_q;
    assign buttons     = buttons_q;
    assign cfg_changed = cfg_changed_q;
    assign cmd_active  = cmd_active_q;
    assign cmd_code    = cmd_code_q;

endmodule
